// File: rtl/result_writeback_pkg.sv
// Shared processor constants for the writeback stage: register-file geometry,
// flag bit positions and the IO handshake state encoding.
package result_writeback_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int DATA_W   = 8;
  localparam int FLAG_W   = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IO_IDLE = 2'd0,
    IO_REQ  = 2'd1,
    IO_DONE = 2'd2
  } io_state_e;

  // One-hot register select, used to build the register-file write mask.
  function automatic logic [NUM_REGS-1:0] regSel(input logic [REG_AW-1:0] idx);
    regSel      = '0;
    regSel[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Signal bundle between the execute stage / IO port and the writeback stage.
interface result_writeback_if;
  import result_writeback_pkg::*;

  logic              EX_Valid;
  logic [DATA_W-1:0] EX_Result;
  logic [REG_AW-1:0] EX_Dest;
  logic              EX_L_R0;
  logic              EX_LRN;
  logic              EX_IOW;
  logic [FLAG_W-1:0] EX_Flags;
  logic [REG_AW-1:0] RdAddr;
  logic              IO_Ack;

  logic              WB_Stall;
  logic [DATA_W-1:0] OF_OD1;
  logic              L_R0;
  logic              LRN;
  logic [REG_AW-1:0] OpcodeCCG4;
  logic              FLRN;
  logic [DATA_W-1:0] R0_Out;
  logic [DATA_W-1:0] RN_Out;
  logic [FLAG_W-1:0] Flags;
  logic              IO_Req;
  logic [DATA_W-1:0] IO_Data;

  modport master (
    output EX_Valid, EX_Result, EX_Dest, EX_L_R0, EX_LRN, EX_IOW, EX_Flags,
           RdAddr, IO_Ack,
    input  WB_Stall, OF_OD1, L_R0, LRN, OpcodeCCG4, FLRN, R0_Out, RN_Out,
           Flags, IO_Req, IO_Data
  );

  modport slave (
    input  EX_Valid, EX_Result, EX_Dest, EX_L_R0, EX_LRN, EX_IOW, EX_Flags,
           RdAddr, IO_Ack,
    output WB_Stall, OF_OD1, L_R0, LRN, OpcodeCCG4, FLRN, R0_Out, RN_Out,
           Flags, IO_Req, IO_Data
  );

endinterface

// File: rtl/result_writeback_regfile8x8.sv
// 8x8 register file: one write data port with a per-register write mask,
// two asynchronous read ports, asynchronous active-low clear.
module regfile8x8
  import result_writeback_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] i_wmask,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [REG_AW-1:0]   i_raddr_a,
  input  logic [REG_AW-1:0]   i_raddr_b,
  output logic [DATA_W-1:0]   o_rdata_a,
  output logic [DATA_W-1:0]   o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // A mask lets R0 and RN share one data bus; a dest of 0 collapses to one write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_wmask[i]) r_regs[i] <= i_wdata;
      end
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/result_writeback.sv
// Stage-4 writeback: holds the completed instruction, commits it to R0/RF/flags,
// and serialises IO writes through a request/acknowledge handshake.
module result_writeback
  import result_writeback_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  result_writeback_if.slave wb
);

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_dest;
  logic              r_lr0;
  logic              r_lrn;
  logic              r_iow;
  logic [FLAG_W-1:0] r_entryFlags;
  logic [FLAG_W-1:0] r_flags;
  io_state_e         r_state;

  io_state_e           w_next;
  logic                w_stall;
  logic                w_ioReq;
  logic                w_commit;
  logic [NUM_REGS-1:0] w_wmask;
  logic [DATA_W-1:0]   w_r0;
  logic [DATA_W-1:0]   w_rn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_dest       <= '0;
      r_lr0        <= 1'b0;
      r_lrn        <= 1'b0;
      r_iow        <= 1'b0;
      r_entryFlags <= '0;
    end else if (!w_stall) begin
      r_valid      <= wb.EX_Valid;
      r_result     <= wb.EX_Result;
      r_dest       <= wb.EX_Dest;
      r_lr0        <= wb.EX_L_R0;
      r_lrn        <= wb.EX_LRN;
      r_iow        <= wb.EX_IOW;
      r_entryFlags <= wb.EX_Flags;
    end
  end

  // An entry retires on the first edge where it is no longer stalling the pipe.
  assign w_commit = r_valid && !w_stall;
  assign w_wmask  = w_commit ? ((r_lr0 ? regSel('0) : '0) | (r_lrn ? regSel(r_dest) : '0))
                             : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_commit && !r_iow) begin
      r_flags <= r_entryFlags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IO_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_ioReq = 1'b0;
    case (r_state)
      IO_IDLE: begin
        if (r_valid && r_iow) begin
          w_stall = 1'b1;
          w_next  = IO_REQ;
        end
      end
      IO_REQ: begin
        w_stall = 1'b1;
        w_ioReq = 1'b1;
        if (wb.IO_Ack) w_next = IO_DONE;
      end
      IO_DONE: w_next = IO_IDLE;
      default: w_next = IO_IDLE;
    endcase
  end

  regfile8x8 u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wmask   (w_wmask),
    .i_wdata   (r_result),
    .i_raddr_a ('0),
    .i_raddr_b (wb.RdAddr),
    .o_rdata_a (w_r0),
    .o_rdata_b (w_rn)
  );

  assign wb.WB_Stall   = w_stall;
  assign wb.OF_OD1     = r_result;
  assign wb.L_R0       = r_valid && r_lr0;
  assign wb.LRN        = r_valid && r_lrn;
  assign wb.OpcodeCCG4 = r_dest;
  assign wb.FLRN       = r_valid && r_lrn && (r_dest == wb.RdAddr);
  assign wb.R0_Out     = w_r0;
  assign wb.RN_Out     = w_rn;
  assign wb.Flags      = r_flags;
  assign wb.IO_Req     = w_ioReq;
  assign wb.IO_Data    = w_ioReq ? r_result : '0;

endmodule

// File: tb/tb_result_writeback.sv
// Directed-vector bench for result_writeback: commit, forwarding, IO handshake
// and reset-in-REQ scenarios with hand-computed expectations.
module tb_result_writeback;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  result_writeback_if wbIf ();

  result_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] result,
                               input logic [2:0] dest, input logic lr0,
                               input logic lrn, input logic iow,
                               input logic [3:0] flags);
    wbIf.EX_Valid  = valid;
    wbIf.EX_Result = result;
    wbIf.EX_Dest   = dest;
    wbIf.EX_L_R0   = lr0;
    wbIf.EX_LRN    = lrn;
    wbIf.EX_IOW    = iow;
    wbIf.EX_Flags  = flags;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst_n     = 1'b0;
    wbIf.RdAddr = 3'd0;
    wbIf.IO_Ack = 1'b0;
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    #3;
    checkOutput("rstStall", wbIf.WB_Stall, 0);
    checkOutput("rstIoReq", wbIf.IO_Req, 0);
    checkOutput("rstR0", wbIf.R0_Out, 0);
    checkOutput("rstFlags", wbIf.Flags, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // R0 load: forward next cycle, architectural one edge later
    applyStimulus(1, 8'h5A, 3'd0, 1, 0, 0, 4'hA);
    tick();
    checkOutput("r0Fwd", wbIf.OF_OD1, 8'h5A);
    checkOutput("r0LoadFlag", wbIf.L_R0, 1);
    checkOutput("r0PreCommit", wbIf.R0_Out, 8'h00);
    checkOutput("r0NoStall", wbIf.WB_Stall, 0);
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("r0Commit", wbIf.R0_Out, 8'h5A);
    checkOutput("r0Flags", wbIf.Flags, 4'hA);
    checkOutput("bubbleLR0", wbIf.L_R0, 0);

    // RN load with matching read address
    wbIf.RdAddr = 3'd3;
    applyStimulus(1, 8'hC3, 3'd3, 0, 1, 0, 4'h5);
    tick();
    checkOutput("rnFlrn", wbIf.FLRN, 1);
    checkOutput("rnDest", wbIf.OpcodeCCG4, 3'd3);
    checkOutput("rnPreCommit", wbIf.RN_Out, 8'h00);
    wbIf.RdAddr = 3'd2;
    #1;
    checkOutput("rnFlrnOther", wbIf.FLRN, 0);
    wbIf.RdAddr = 3'd3;
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("rnCommit", wbIf.RN_Out, 8'hC3);
    checkOutput("rnFlrnAfter", wbIf.FLRN, 0);
    checkOutput("rnFlags", wbIf.Flags, 4'h5);
    checkOutput("rnR0Kept", wbIf.R0_Out, 8'h5A);

    // IO write with a slow acknowledge
    applyStimulus(1, 8'h77, 3'd0, 0, 0, 1, 4'hF);
    tick();
    checkOutput("ioIdleStall", wbIf.WB_Stall, 1);
    checkOutput("ioIdleReq", wbIf.IO_Req, 0);
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ioReq%0d", i), wbIf.IO_Req, 1);
      checkOutput($sformatf("ioData%0d", i), wbIf.IO_Data, 8'h77);
      checkOutput($sformatf("ioStall%0d", i), wbIf.WB_Stall, 1);
      if (i < 3) tick();
    end
    wbIf.IO_Ack = 1'b1;
    tick();
    checkOutput("ioDoneReq", wbIf.IO_Req, 0);
    checkOutput("ioDoneStall", wbIf.WB_Stall, 0);
    wbIf.IO_Ack = 1'b0;
    tick();
    checkOutput("ioFlagsKept", wbIf.Flags, 4'h5);
    checkOutput("ioAfterReq", wbIf.IO_Req, 0);

    // Back-to-back IO writes with acknowledge tied high
    wbIf.IO_Ack = 1'b1;
    applyStimulus(1, 8'h11, 3'd0, 0, 0, 1, 4'h0);
    tick();
    checkOutput("b2bIdleStall", wbIf.WB_Stall, 1);
    checkOutput("b2bReqA0", wbIf.IO_Req, 0);
    applyStimulus(1, 8'h22, 3'd0, 0, 0, 1, 4'h0);
    tick();
    checkOutput("b2bReqA", wbIf.IO_Req, 1);
    checkOutput("b2bDataA", wbIf.IO_Data, 8'h11);
    tick();
    checkOutput("b2bGap", wbIf.IO_Req, 0);
    tick();
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    checkOutput("b2bGap2", wbIf.IO_Req, 0);
    checkOutput("b2bFwdB", wbIf.OF_OD1, 8'h22);
    tick();
    checkOutput("b2bReqB", wbIf.IO_Req, 1);
    checkOutput("b2bDataB", wbIf.IO_Data, 8'h22);
    tick();
    checkOutput("b2bDoneB", wbIf.IO_Req, 0);
    wbIf.IO_Ack = 1'b0;
    tick();

    // Reset while requesting: drop at once, no commit afterwards
    applyStimulus(1, 8'h66, 3'd0, 1, 0, 1, 4'h9);
    tick();
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    tick();
    checkOutput("rstInReq", wbIf.IO_Req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstReqDrop", wbIf.IO_Req, 0);
    checkOutput("rstR0Clear", wbIf.R0_Out, 8'h00);
    checkOutput("rstStallDrop", wbIf.WB_Stall, 0);
    checkOutput("rstFwdClear", wbIf.OF_OD1, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("postRstR0", wbIf.R0_Out, 8'h00);
    checkOutput("postRstReq", wbIf.IO_Req, 0);
    checkOutput("postRstFlags", wbIf.Flags, 4'h0);
    checkOutput("postRstRn", wbIf.RN_Out, 8'h00);

    // Dual load with dest R0 writes R0 only
    wbIf.RdAddr = 3'd0;
    applyStimulus(1, 8'h44, 3'd4, 0, 1, 0, 4'h1);
    tick();
    applyStimulus(1, 8'h3C, 3'd0, 1, 1, 0, 4'h2);
    tick();
    applyStimulus(0, 8'h00, 3'd0, 0, 0, 0, 4'h0);
    checkOutput("dualLR0", wbIf.L_R0, 1);
    checkOutput("dualLRN", wbIf.LRN, 1);
    checkOutput("dualFlrn", wbIf.FLRN, 1);
    tick();
    checkOutput("dualR0", wbIf.R0_Out, 8'h3C);
    checkOutput("dualFlags", wbIf.Flags, 4'h2);
    for (int i = 1; i < 8; i++) begin
      wbIf.RdAddr = 3'(i);
      #1;
      checkOutput($sformatf("dualRf%0d", i), wbIf.RN_Out, (i == 4) ? 8'h44 : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have the port clk, input, width 1, the single rising-edge clock.
REQ-002 SHALL have the port rst_n, input, width 1, an asynchronous active-low reset.
REQ-003 SHALL have the port EX_Valid, input, width 1, meaning stage-3 presents a completed instruction.
REQ-004 SHALL have the port EX_Result, input, width 8, the ALU or memory result.
REQ-005 SHALL have the port EX_Dest, input, width 3, the destination register index, where 000 = R0.
REQ-006 SHALL have the port EX_L_R0, input, width 1, meaning the instruction loads R0.
REQ-007 SHALL have the port EX_LRN, input, width 1, meaning the instruction loads RN (EX_Dest).
REQ-008 SHALL have the port EX_IOW, input, width 1, meaning the instruction writes EX_Result to the IO port.
REQ-009 SHALL have the port EX_Flags, input, width 4, the Z/C/S/V flags produced by the instruction.
REQ-010 SHALL have the port RdAddr, input, width 3, the register-file read index from operand decode.
REQ-011 SHALL have the port IO_Ack, input, width 1, the external acknowledge of IO_Req.
REQ-012 SHALL have the port WB_Stall, output, width 1, which holds stages 1-3.
REQ-013 SHALL have the port OF_OD1, output, width 8, the forwarded stage-4 result.
REQ-014 SHALL have the port L_R0, output, width 1, the registered stage-4 R0 load.
REQ-015 SHALL have the port LRN, output, width 1, the registered stage-4 RN load.
REQ-016 SHALL have the port OpcodeCCG4, output, width 3, the registered stage-4 destination index.
REQ-017 SHALL have the port FLRN, output, width 1, the per-register forward flag for RdAddr.
REQ-018 SHALL have the port R0_Out, output, width 8, the architectural R0.
REQ-019 SHALL have the port RN_Out, output, width 8, the register-file value at RdAddr.
REQ-020 SHALL have the port Flags, output, width 4, the architectural flags.
REQ-021 SHALL have the port IO_Req, output, width 1, the IO write request.
REQ-022 SHALL have the port IO_Data, output, width 8, the IO write data.

Function
REQ-023 Stage-4 register SHALL capture EX_* on the clk edge when WB_Stall=0; it SHALL hold while WB_Stall=1.
REQ-024 A captured entry with EX_Valid=0 SHALL be a bubble; L_R0, LRN and IO_Req SHALL be 0 for a bubble.
REQ-025 OF_OD1, L_R0, LRN and OpcodeCCG4 SHALL reflect the stage-4 entry combinationally from its registers, with zero added latency.
REQ-026 Commit: on the edge ending a valid stage-4 entry's last cycle, R0 SHALL take OF_OD1 if L_R0, and RF[OpcodeCCG4] SHALL take OF_OD1 if LRN; total write latency SHALL be 2 edges from EX capture.
REQ-027 If both L_R0 and LRN are set with OpcodeCCG4=000, R0 SHALL be written once with OF_OD1.
REQ-028 R0_Out SHALL equal RF[0]; RN_Out SHALL equal RF[RdAddr]; reads SHALL return the pre-commit value in the commit cycle, with no write-through.
REQ-029 FLRN SHALL be 1 iff LRN=1 and OpcodeCCG4==RdAddr.
REQ-030 Flags SHALL update from the stage-4 flags at commit of every valid non-IO entry.
REQ-031 The IO FSM SHALL have the states IDLE, REQ and DONE.
REQ-032 In IDLE, a valid stage-4 entry with EX_IOW SHALL go to REQ.
REQ-033 In REQ, IO_Req SHALL be 1 and IO_Data SHALL equal OF_OD1, held stable; the FSM SHALL stay in REQ until IO_Ack=1, then go to DONE.
REQ-034 In DONE, IO_Req SHALL be 0, the entry SHALL commit, and the FSM SHALL go to IDLE after one cycle.
REQ-035 WB_Stall SHALL be 1 in IDLE when the stage-4 entry is a valid IOW entry, and throughout REQ; it SHALL be 0 in DONE.
REQ-036 If IO_Ack is already high on entry to REQ, the FSM SHALL leave REQ after exactly one REQ cycle.
REQ-037 IO_Ack outside REQ SHALL be ignored.
REQ-038 Back-to-back IOW entries SHALL each produce a separate REQ phase, with IO_Req low for at least 1 cycle (DONE) between them.

Reset
REQ-039 rst_n=0 SHALL asynchronously clear the stage-4 entry to a bubble, RF[0..7] to 8'h00, Flags to 4'h0, and the FSM to IDLE.
REQ-040 All outputs SHALL be 0 during reset.
REQ-041 A reset asserted in REQ SHALL drop IO_Req immediately and discard the entry without commit.
REQ-042 Deassertion SHALL take effect on the first clk edge after rst_n rises.

Structure
REQ-043 The IO state encodings, the flag bit positions (Z=3, C=2, S=1, V=0) and the register-count constant 8 SHALL reside in the shared processor package.
REQ-044 The register file SHALL be one sub-module, regfile8x8, with 1 write port, 2 asynchronous read ports (R0, RdAddr) and asynchronous reset.

Verification
REQ-045 The bench SHALL drive EX_Valid=1, EX_L_R0=1, EX_Result=8'h5A; it SHALL then check the next cycle for OF_OD1=5A and L_R0=1, and one edge later for R0_Out=5A.
REQ-046 The bench SHALL drive EX_LRN=1, EX_Dest=3, EX_Result=8'hC3 with RdAddr=3, and SHALL check FLRN=1 in stage 4 and RN_Out=C3 after commit.
REQ-047 The bench SHALL drive EX_IOW=1, EX_Result=8'h77 with IO_Ack held low for 4 cycles, and SHALL check IO_Req=1, IO_Data=77 and WB_Stall=1 for 4 cycles, then DONE and WB_Stall=0.
REQ-048 The bench SHALL drive two consecutive IOW entries (11, 22) with IO_Ack tied high, and SHALL check IO_Req pulses 1,0,1 with data 11 then 22.
REQ-049 The bench SHALL assert rst_n=0 in REQ, and SHALL check IO_Req=0 at once, R0_Out=00, and no commit after release.
REQ-050 The bench SHALL drive EX_L_R0=1 and EX_LRN=1 with Dest=0 and Result=8'h3C, and SHALL check R0_Out=3C with RF[1..7] unchanged.
